dna_axi_lite_host_seq: RTL
==========================

Name: dna_axi_lite_host_seq

Overview:
- AXI-Lite master that drives the DNA accelerator's register slave from the host side.
- On one command pulse it performs the full run sequence:
  - write the config register;
  - write start=1;
  - poll the status register until matrix_full is set, or until the poll limit is reached;
  - write start=0;
  - report done.
- Sits between a local controller/testbench and the accelerator's AXI-Lite port. There are no bresp/rresp channels, matching the slave.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width.
- BASE_ADDR, 32'h0200_4000, register block base. Start register = +0x0, config = +0x4, status = +0xC.
- POLL_GAP, 16, idle cycles between consecutive status reads (≥1).
- POLL_LIMIT, 1024, maximum status reads before timeout.
- DONE_BIT, 2, status bit that indicates completion (matrix_full).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- cmd_start_i  in  1  one-cycle run request; ignored while busy_o=1.
- cfg_len_i  in  7  read length, written to config[6:0].
- cfg_match_i  in  3  match score, written to config[9:7].
- cfg_mismatch_i  in  3  mismatch score, written to config[12:10].
- cfg_gap_i  in  3  gap score, written to config[15:13].
- busy_o  out  1  high from accept until done_o.
- done_o  out  1  one-cycle pulse at sequence end.
- timeout_o  out  1  sticky; set on poll-limit expiry, cleared on next accepted cmd_start_i.
- status_o  out  DATA_WIDTH  last status word read.
- poll_cnt_o  out  11  number of status reads in the current/last run.
- o_axi_awaddr  out  ADDR_WIDTH; o_axi_awvalid  out  1; i_axi_awready  in  1.
- o_axi_wdata  out  DATA_WIDTH; o_axi_wstrb  out  4; o_axi_wvalid  out  1; i_axi_wready  in  1.
- i_axi_bvalid  in  1; o_axi_bready  out  1.
- o_axi_araddr  out  ADDR_WIDTH; o_axi_arvalid  out  1; i_axi_arready  in  1.
- i_axi_rdata  in  DATA_WIDTH; i_axi_rvalid  in  1; o_axi_rready  out  1.

Behaviour:
- Reset values:
  - All valid/ready outputs, busy_o, done_o and timeout_o = 0.
  - status_o and poll_cnt_o = 0; addr/data outputs = 0; wstrb = 4'hF.
  - FSM = IDLE.
  - Asserting reset mid-transaction drops all valids immediately. Any outstanding slave response is not awaited.
- FSM states: IDLE, WR_CFG, WR_START, RD_STATUS, POLL_WAIT, WR_STOP, FINISH.
- IDLE:
  - cmd_start_i=1 latches the cfg inputs, clears timeout_o and poll_cnt_o, sets busy_o, and goes to WR_CFG.
  - awvalid is asserted the following cycle.
- Write sub-sequence (WR_CFG, WR_START, WR_STOP):
  - Drive awaddr/wdata; awvalid and wvalid rise in the same cycle.
  - Each valid drops the cycle after its own handshake (valid&ready). AW and W may complete in either order or together.
  - Once both have completed, bready=1 until bvalid. Handshake on bvalid&bready, then advance.
  - awaddr/wdata are held stable while their valid is high.
  - Config data = {16'b0, gap, mismatch, match, len}. Start data = 1. Stop data = 0.
- Transitions: WR_CFG → WR_START → RD_STATUS.
- RD_STATUS:
  - arvalid=1 with araddr=BASE+0xC until arready. Then rready=1 until rvalid.
  - On the r handshake: capture rdata into status_o and increment poll_cnt_o.
  - Next state:
    - If rdata[DONE_BIT]=1 → WR_STOP.
    - Else if poll_cnt (after increment) == POLL_LIMIT → set timeout_o → WR_STOP.
    - Else → POLL_WAIT.
- POLL_WAIT: a counter runs POLL_GAP cycles, then returns to RD_STATUS.
- WR_STOP → FINISH.
- FINISH: done_o=1 for exactly one cycle, busy_o falls in the same cycle, then IDLE.
  - A cmd_start_i arriving in the FINISH cycle is ignored.
  - It is accepted from the next cycle, in IDLE.
- No more than one AXI transaction is outstanding at any time. Read and write channels are never active simultaneously.
- poll_cnt saturates at POLL_LIMIT; 11 bits is sufficient for the default POLL_LIMIT.
- Ready inputs asserted before the corresponding valid are legal. The handshake occurs only when both are high.

Test Plan:
- Ready-always slave, cfg len=64, match=2, mismatch=1, gap=3; status returns bit2=1 on the 3rd read:
  - config wdata=32'h0000_6540 to addr 0x0200_4004;
  - then 1 written to 0x0200_4000;
  - then 3 reads of 0x0200_400C;
  - then 0 written to 0x0200_4000;
  - done_o pulses once, poll_cnt_o=3, timeout_o=0.
- wready asserted 5 cycles before awready, and vice versa → each valid drops independently; bready rises only after both handshakes; all writes complete correctly.
- Status never sets bit2, POLL_LIMIT=4 → exactly 4 reads spaced ≥POLL_GAP cycles apart, then the stop write; timeout_o=1, done_o pulses.
- Slave stalls bvalid for 20 cycles, and arready/rvalid for 7 cycles → addr/data held stable throughout; no new valid is asserted until the prior response completes.
- cmd_start_i pulsed while busy, and in the FINISH cycle → ignored. A pulse the following cycle starts a new run and clears timeout_o.
- resetn deasserted while awvalid=1 → all outputs return to reset values asynchronously. After reset release, a new command runs cleanly.

Source files
------------

// File: rtl/dna_axi_lite_host_seq.sv
// AXI-Lite host sequencer for the DNA accelerator: writes config, starts the run,
// polls status until matrix_full or poll limit, then stops and reports done.
module dna_axi_lite_host_seq #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = ADDR_WIDTH'(32'h0200_4000),
  parameter int unsigned             POLL_GAP   = 16,
  parameter int unsigned             POLL_LIMIT = 1024,
  parameter int unsigned             DONE_BIT   = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_start_i,
  input  logic [6:0]            cfg_len_i,
  input  logic [2:0]            cfg_match_i,
  input  logic [2:0]            cfg_mismatch_i,
  input  logic [2:0]            cfg_gap_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] status_o,
  output logic [10:0]           poll_cnt_o,
  output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [DATA_WIDTH-1:0] o_axi_wdata,
  output logic [3:0]            o_axi_wstrb,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  input  logic                  i_axi_bvalid,
  output logic                  o_axi_bready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_axi_rdata,
  input  logic                  i_axi_rvalid,
  output logic                  o_axi_rready
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [ADDR_WIDTH-1:0] START_ADDR  = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] CFG_ADDR    = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(12);
  localparam logic [CNT_W-1:0]      LIMIT_C     = CNT_W'(POLL_LIMIT);
  localparam logic [GAP_W-1:0]      GAP_LAST    = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, WR_CFG, WR_START, RD_STATUS, POLL_WAIT, WR_STOP, FINISH
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr;
  logic                  r_awvalid, w_awvalid;
  logic                  r_wvalid, w_wvalid;
  logic                  r_bready, w_bready;
  logic                  r_arvalid, w_arvalid;
  logic                  r_rready, w_rready;
  logic                  r_aw_done, w_aw_done;
  logic                  r_w_done, w_w_done;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_timeout, w_timeout;
  logic [DATA_WIDTH-1:0] r_status, w_status;
  logic [CNT_W-1:0]      r_poll_cnt, w_poll_cnt;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt;

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [15:0]           w_cfg_word;
  logic [CNT_W-1:0]      w_poll_inc;
  logic                  w_done_bit;

  assign w_aw_hs    = r_awvalid & i_axi_awready;
  assign w_w_hs     = r_wvalid  & i_axi_wready;
  assign w_b_hs     = r_bready  & i_axi_bvalid;
  assign w_ar_hs    = r_arvalid & i_axi_arready;
  assign w_r_hs     = r_rready  & i_axi_rvalid;
  assign w_cfg_word = {cfg_gap_i, cfg_mismatch_i, cfg_match_i, cfg_len_i};
  assign w_poll_inc = (r_poll_cnt == LIMIT_C) ? r_poll_cnt : r_poll_cnt + CNT_W'(1);
  assign w_done_bit = i_axi_rdata[DONE_BIT];

  // State register and all registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_araddr   <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_status   <= '0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state;
      r_awaddr   <= w_awaddr;
      r_wdata    <= w_wdata;
      r_araddr   <= w_araddr;
      r_awvalid  <= w_awvalid;
      r_wvalid   <= w_wvalid;
      r_bready   <= w_bready;
      r_arvalid  <= w_arvalid;
      r_rready   <= w_rready;
      r_aw_done  <= w_aw_done;
      r_w_done   <= w_w_done;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_timeout  <= w_timeout;
      r_status   <= w_status;
      r_poll_cnt <= w_poll_cnt;
      r_gap_cnt  <= w_gap_cnt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_awaddr   = r_awaddr;
    w_wdata    = r_wdata;
    w_araddr   = r_araddr;
    w_awvalid  = r_awvalid;
    w_wvalid   = r_wvalid;
    w_bready   = r_bready;
    w_arvalid  = r_arvalid;
    w_rready   = r_rready;
    w_aw_done  = r_aw_done;
    w_w_done   = r_w_done;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_timeout  = r_timeout;
    w_status   = r_status;
    w_poll_cnt = r_poll_cnt;
    w_gap_cnt  = r_gap_cnt;

    unique case (r_state)
      IDLE: begin
        if (cmd_start_i) begin
          w_state    = WR_CFG;
          w_busy     = 1'b1;
          w_timeout  = 1'b0;
          w_poll_cnt = '0;
          w_awaddr   = CFG_ADDR;
          w_wdata    = DATA_WIDTH'(w_cfg_word);
          w_awvalid  = 1'b1;
          w_wvalid   = 1'b1;
          w_aw_done  = 1'b0;
          w_w_done   = 1'b0;
        end
      end

      // Shared write handler: AW and W retire independently, then wait for B
      WR_CFG, WR_START, WR_STOP: begin
        if (w_aw_hs) begin
          w_awvalid = 1'b0;
          w_aw_done = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid = 1'b0;
          w_w_done = 1'b1;
        end
        if (w_b_hs) begin
          w_bready  = 1'b0;
          w_aw_done = 1'b0;
          w_w_done  = 1'b0;
          if (r_state == WR_CFG) begin
            w_state   = WR_START;
            w_awaddr  = START_ADDR;
            w_wdata   = DATA_WIDTH'(1);
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else if (r_state == WR_START) begin
            w_state   = RD_STATUS;
            w_araddr  = STATUS_ADDR;
            w_arvalid = 1'b1;
          end else begin
            w_state = FINISH;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end
        end else if (w_aw_done && w_w_done) begin
          w_bready = 1'b1;
        end
      end

      RD_STATUS: begin
        if (w_ar_hs) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
        end
        if (w_r_hs) begin
          w_rready   = 1'b0;
          w_status   = i_axi_rdata;
          w_poll_cnt = w_poll_inc;
          if (w_done_bit || (w_poll_inc == LIMIT_C)) begin
            w_timeout = r_timeout | ~w_done_bit;
            w_state   = WR_STOP;
            w_awaddr  = START_ADDR;
            w_wdata   = '0;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else begin
            w_state   = POLL_WAIT;
            w_gap_cnt = '0;
          end
        end
      end

      // Idle spacing between status reads
      POLL_WAIT: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state   = RD_STATUS;
          w_arvalid = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end

      FINISH: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign timeout_o     = r_timeout;
  assign status_o      = r_status;
  assign poll_cnt_o    = r_poll_cnt;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = 4'hF;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_bready  = r_bready;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_rready  = r_rready;

endmodule
